// File: rtl/vga_pkg.sv
// Shared VGA framebuffer definitions for the 160x120 drawing path.
// Contents: screen geometry, pixel field types, the sequencer state
// encoding and an on-screen bounds helper.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef logic [2:0] colour_t;
  typedef logic [7:0] xcoord_t;
  typedef logic [6:0] ycoord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // True when (x, y) lies inside the visible framebuffer.
  function automatic logic on_screen(input xcoord_t x, input ycoord_t y);
    return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
  endfunction

endpackage

// File: rtl/draw_sequencer_plot_clip_reg.sv
// plot_clip_reg: registered 2:1 pixel-stream mux feeding the VGA adapter.
// The fill stream is forwarded as-is; the draw stream has its plot strobe
// suppressed when the coordinate is off-screen. Coordinates and colour are
// registered whenever a stream is selected and hold otherwise.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   clear                       zero the plot counter
//   sel_fill, sel_draw          stream select (at most one high)
//   fill_x/y/c/plot             fill engine pixel stream
//   draw_x/y/c/plot             draw engine pixel stream
//   vga_x/y/colour/plot         registered output to the VGA adapter
//   pix_count                   saturating count of forwarded plots
module plot_clip_reg
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        sel_fill,
  input  logic        sel_draw,
  input  logic [7:0]  fill_x,
  input  logic [6:0]  fill_y,
  input  logic [2:0]  fill_c,
  input  logic        fill_plot,
  input  logic [7:0]  draw_x,
  input  logic [6:0]  draw_y,
  input  logic [2:0]  draw_c,
  input  logic        draw_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] pix_count
);

  logic draw_visible;
  logic plot_next;

  assign draw_visible = draw_plot && on_screen(draw_x, draw_y);

  always_comb begin
    plot_next = 1'b0;
    if (sel_fill) begin
      plot_next = fill_plot;
    end else if (sel_draw) begin
      plot_next = draw_visible;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      pix_count  <= '0;
    end else begin
      vga_plot <= plot_next;
      if (sel_fill) begin
        vga_x      <= fill_x;
        vga_y      <= fill_y;
        vga_colour <= fill_c;
      end else if (sel_draw) begin
        vga_x      <= draw_x;
        vga_y      <= draw_y;
        vga_colour <= draw_c;
      end
      if (clear) begin
        pix_count <= '0;
      end else if (plot_next && (pix_count != '1)) begin
        pix_count <= pix_count + 15'd1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: top-level drawing sequencer. On start it clears the
// screen with the fill engine, then runs the shape-draw engine, and merges
// both pixel streams onto one registered, clipped VGA plot port.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   start                              level run request, held for the run
//   finished                           high once the run has completed
//   fill_rst_n/start/colour, fill_done fill engine control and status
//   fill_x/y/c/plot                    fill engine pixel stream
//   draw_rst_n/start, draw_done        draw engine control and status
//   draw_x/y/c/plot                    draw engine pixel stream
//   vga_x/y/colour/plot                to the VGA adapter
//   pix_count                          plots forwarded in the current run
module draw_sequencer
  import vga_pkg::*;
#(
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        finished,
  output logic        fill_rst_n,
  output logic        fill_start,
  output logic [2:0]  fill_colour,
  input  logic        fill_done,
  input  logic [7:0]  fill_x,
  input  logic [6:0]  fill_y,
  input  logic [2:0]  fill_c,
  input  logic        fill_plot,
  output logic        draw_rst_n,
  output logic        draw_start,
  input  logic        draw_done,
  input  logic [7:0]  draw_x,
  input  logic [6:0]  draw_y,
  input  logic [2:0]  draw_c,
  input  logic        draw_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] pix_count
);

  seq_state_t state;
  seq_state_t state_next;

  logic sel_fill;
  logic sel_draw;
  logic clear_count;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = FILL;
      FILL: begin
        if (!start)         state_next = IDLE;
        else if (fill_done) state_next = DRAW;
      end
      DRAW: begin
        if (!start)         state_next = IDLE;
        else if (draw_done) state_next = DONE;
      end
      DONE: if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Engine controls decode straight from the state register, so an engine
  // is released from reset only one edge after its state is entered.
  assign fill_rst_n  = (state == FILL);
  assign fill_start  = (state == FILL);
  assign draw_rst_n  = (state == DRAW);
  assign draw_start  = (state == DRAW);
  assign finished    = (state == DONE);
  assign fill_colour = BG_COLOUR;

  // Gating the select with start makes an abort win over a same-cycle
  // engine pixel: the pixel presented while start falls is dropped.
  assign sel_fill    = (state == FILL) && start;
  assign sel_draw    = (state == DRAW) && start;
  assign clear_count = (state == IDLE) && start;

  plot_clip_reg u_plot_clip_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_count),
    .sel_fill   (sel_fill),
    .sel_draw   (sel_draw),
    .fill_x     (fill_x),
    .fill_y     (fill_y),
    .fill_c     (fill_c),
    .fill_plot  (fill_plot),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_c     (draw_c),
    .draw_plot  (draw_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .pix_count  (pix_count)
  );

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Top-level drawing sequencer for the 160x120 VGA framebuffer path. On a user `start` it runs the screen-fill engine to clear the background, then the shape-draw engine (circle / Reuleaux). It multiplexes both engines' pixel streams onto one registered, clipped plot port that drives the VGA adapter. It owns engine resets, so every run starts from fresh counters.

## Interface
- `BG_COLOUR`, default 3'b000: colour driven to the fill engine.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: level request; held high for the whole run.
- `finished` out 1: high in DONE.
- `fill_rst_n` out 1: fill engine reset, active-low.
- `fill_start` out 1: fill engine start.
- `fill_colour` out 3: constant `BG_COLOUR`.
- `fill_done` in 1: fill engine finished.
- `fill_x` in 8, `fill_y` in 7, `fill_c` in 3, `fill_plot` in 1: fill pixel stream.
- `draw_rst_n` out 1, `draw_start` out 1: draw engine control.
- `draw_done` in 1: draw engine finished.
- `draw_x` in 8, `draw_y` in 7, `draw_c` in 3, `draw_plot` in 1: draw pixel stream; may be off-screen.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3, `vga_plot` out 1: to the VGA adapter.
- `pix_count` out 15: pixels forwarded with plot=1 in the current run.

## Operation
- States: IDLE, FILL, DRAW, DONE. Reset enters IDLE.
- IDLE:
  - `fill_rst_n`=`draw_rst_n`=0; both starts 0.
  - `start`=1 → FILL, and `pix_count` clears to 0.
- FILL:
  - `fill_rst_n`=1, `fill_start`=1, `draw_rst_n`=0.
  - Forward the fill stream.
  - `fill_done`=1 → DRAW. The pixel presented in that same cycle is forwarded; the last fill pixel is (159,119).
- DRAW:
  - `fill_rst_n`=0, `draw_rst_n`=1, `draw_start`=1.
  - Forward the draw stream with clipping.
  - `draw_done`=1 → DONE. That cycle's pixel is forwarded.
- DONE:
  - Both engines held in reset; `finished`=1.
  - `start`=0 → IDLE.
- Abort: `start`=0 in FILL or DRAW → IDLE next cycle. No further pixels are forwarded, and engines return to reset.
- Clipping (DRAW only): if `draw_x`≥160 or `draw_y`≥120, `vga_plot`=0 and `pix_count` does not increment. x/y/colour are still registered.
- In IDLE and DONE, the selected stream is none: `vga_plot`=0, and x/y/colour hold their last value.
- `pix_count`:
  - Increments by 1 for each forwarded plot.
  - Saturates at 32767.
  - Holds in DONE; clears only on the IDLE→FILL transition.
- Simultaneous `fill_done` and `start`=0 in FILL: abort wins. The pixel is not forwarded; next state is IDLE.

## Timing
- Reset values:
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0.
  - `pix_count`=0, `finished`=0.
  - Both `*_rst_n`=0, both `*_start`=0.
- Engine control outputs (`*_rst_n`, `*_start`, `finished`) are decoded combinationally from the state register.
- Pixel path latency is 1 cycle: the engine pixel at cycle N appears on `vga_*` at N+1.
- `pix_count` updates in the same edge as the corresponding `vga_plot`.
- First fill pixel: `start` sampled at edge 0 → FILL. The engine leaves reset at edge 1, giving pixel (0,0) during cycle 1, which appears on `vga_*` after edge 2.
- A full fill forwards 19200 pixels. `vga_plot` on the last fill pixel is the cycle after `fill_done`.
- FILL→DRAW: the draw engine is in reset during the last fill cycle and leaves reset one edge after entering DRAW.
- `finished` rises on the edge after `draw_done` is sampled, coincident with the last draw pixel on `vga_*`.

## Structure
- Shared package `vga_pkg`:
  - `SCREEN_W`=160, `SCREEN_H`=120.
  - `colour_t` (logic [2:0]), `xcoord_t` [7:0], `ycoord_t` [6:0].
  - Enum `seq_state_t` {IDLE, FILL, DRAW, DONE}.
- One sub-module, `plot_clip_reg`: a registered 2:1 stream mux with bounds clip and plot counter. The sequencer FSM stays in the top.

## Test plan
- Full run with behavioural fill (all 19200 pixels, colour 000) and a draw model emitting 50 on-screen pixels → `pix_count`=19250, `finished`=1, first `vga_*`=(0,0,000) with plot=1, last fill pixel (159,119).
- Draw model emits (160,10), (5,120), (255,127), (10,10) all with plot=1 → only (10,10) plots, `pix_count` advance is 1.
- Drop `start` after 100 fill pixels → IDLE next cycle, `vga_plot`=0 thereafter, `fill_rst_n`=0, `pix_count` stays 100 until the next start.
- Assert `rst_n`=0 for one cycle mid-DRAW → all outputs take reset values, IDLE. Re-issue `start` → fill restarts at (0,0).
- From DONE, keep `start`=1 for 20 cycles → `finished` stays 1, no plots. Drop `start`, then reassert → `pix_count` clears, new run completes.
- `fill_done` and `start`=0 asserted in the same cycle → next state IDLE, no DRAW entry, `draw_start` never asserted.
